// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IF/DM memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// slave: the arbiter's view. master: the requesters and memory side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_rsp_valid;
    logic [DATA_W-1:0]     if_rsp_rdata;

    logic                  dm_req_valid;
    logic                  dm_req_ready;
    logic [ADDR_W-1:0]     dm_req_addr;
    logic                  dm_req_we;
    logic [DATA_W/8-1:0]   dm_req_be;
    logic [DATA_W-1:0]     dm_req_wdata;
    logic                  dm_rsp_valid;
    logic [DATA_W-1:0]     dm_rsp_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  err_spurious;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_be, dm_req_wdata,
        output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output err_spurious
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output dm_req_valid, dm_req_addr, dm_req_we, dm_req_be, dm_req_wdata,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
        input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  err_spurious
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IF and DM.
// Build option MEM_ARB_ROUND_ROBIN_EN: on a conflict the requester that did
// not own the previous transaction wins. Without it DM always wins a conflict.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_valid,
    input  logic   dm_valid,
    input  owner_e last_owner,
    output logic   grant_if,
    output logic   grant_dm
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // last_owner is tracked by the top in both builds; fixed priority ignores it.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Grant at most one requester; a lone requester always wins.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (if_valid && dm_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_owner == OWN_IF) begin
                grant_dm = 1'b1;
            end else begin
                grant_if = 1'b1;
            end
`else
            grant_dm = 1'b1;
`endif
        end else begin
            grant_if = if_valid;
            grant_dm = dm_valid;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the core memory port between instruction fetch and data access.
// One transaction in flight; the response is routed back to its owner.
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
//
// state | meaning
// IDLE  | no transaction; accept the winning requester
// REQ   | latched request presented to memory, waiting for mem_req_ready
// WAIT  | request taken by memory, waiting for mem_rsp_valid
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
)(
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);

    arb_state_e state_q, state_d;
    owner_e     owner_q;
    owner_e     last_owner_q;
    mem_req_t   req_q;
    logic       err_q;

    logic grant_if, grant_dm;
    logic accept_if, accept_dm;
    logic rsp_fire;

    logic [DATA_W-1:0] rdata_sel;
    logic              if_rsp_fire, dm_rsp_fire;

    mem_arb_pick u_pick (
        .if_valid   (bus.if_req_valid),
        .dm_valid   (bus.dm_req_valid),
        .last_owner (last_owner_q),
        .grant_if   (grant_if),
        .grant_dm   (grant_dm)
    );

    // Next-state and handshake decode. Accept and response are both held off
    // while rst_n is low so a reset cycle never shows a handshake or pulse.
    always_comb begin
        state_d   = state_q;
        accept_if = 1'b0;
        accept_dm = 1'b0;
        rsp_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                accept_if = rst_n && grant_if;
                accept_dm = rst_n && grant_dm;
                if (accept_if || accept_dm) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    rsp_fire = rst_n;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted request and its owner; IF is always a full-word read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q        <= '0;
            owner_q      <= OWN_DM;
            last_owner_q <= OWN_DM;
        end else if (accept_dm) begin
            req_q.addr   <= MEM_ADDR_W'(bus.dm_req_addr);
            req_q.we     <= bus.dm_req_we;
            req_q.be     <= MEM_BE_W'(bus.dm_req_be);
            req_q.wdata  <= MEM_DATA_W'(bus.dm_req_wdata);
            owner_q      <= OWN_DM;
            last_owner_q <= OWN_DM;
        end else if (accept_if) begin
            req_q.addr   <= MEM_ADDR_W'(bus.if_req_addr);
            req_q.we     <= 1'b0;
            req_q.be     <= '1;
            req_q.wdata  <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
        end
    end

    // Sticky flag for a memory response arriving with nothing waiting for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.mem_rsp_valid && (state_q != WAIT)) begin
            err_q <= 1'b1;
        end
    end

    // Response steering: read data passes straight through in the cycle memory
    // answers; write acks return zero data.
    always_comb begin
        rdata_sel   = DATA_W'(bus.mem_rdata);
        if_rsp_fire = rsp_fire && (owner_q == OWN_IF);
        dm_rsp_fire = rsp_fire && (owner_q == OWN_DM);
    end

    assign bus.if_req_ready  = accept_if;
    assign bus.dm_req_ready  = accept_dm;
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_addr      = req_q.addr;
    assign bus.mem_we        = req_q.we;
    assign bus.mem_be        = req_q.be;
    assign bus.mem_wdata     = req_q.wdata;
    assign bus.if_rsp_valid  = if_rsp_fire;
    assign bus.if_rsp_rdata  = if_rsp_fire ? rdata_sel : {DATA_W{1'b0}};
    assign bus.dm_rsp_valid  = dm_rsp_fire;
    assign bus.dm_rsp_rdata  = (dm_rsp_fire && !req_q.we) ? rdata_sel : {DATA_W{1'b0}};
    assign bus.err_spurious  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants and
// responses into queues; monitors pop and compare when the DUT shows them.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        is_dm;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_rsp_q[$];
    logic exp_grant_q[$];   // 1 = DM, 0 = IF

    int n_pass  = 0;
    int n_total = 0;

    // memory model controls
    logic        mem_auto    = 1'b1;
    int          stall_cycles = 0;
    logic        inj_rsp     = 1'b0;
    logic        inj_ready   = 1'b0;
    logic [31:0] inj_data    = '0;
    logic        mem_busy    = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Memory model: drives its outputs at posedge+2 so stimulus flags set at
    // posedge+1 are already settled.
    initial begin : mem_model
        int          ph;
        int          left;
        logic [31:0] addr;
        ph = 0; left = 0; addr = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        forever begin
            @(posedge clk); #2;
            bus.mem_req_ready = inj_ready;
            bus.mem_rsp_valid = inj_rsp;
            bus.mem_rdata     = inj_rsp ? inj_data : 32'h0;
            if (mem_auto) begin
                case (ph)
                    0: if (bus.mem_req_valid) begin
                        addr = bus.mem_addr;
                        if (stall_cycles == 0) begin
                            bus.mem_req_ready = 1'b1; ph = 2;
                        end else begin
                            left = stall_cycles - 1; ph = 1;
                        end
                    end
                    1: begin
                        check("stall_hold_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
                        if (left == 0) begin
                            bus.mem_req_ready = 1'b1; ph = 2;
                        end else begin
                            left--;
                        end
                    end
                    default: begin
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rdata     = mem_data(addr);
                        ph = 0;
                    end
                endcase
            end
            mem_busy = (ph != 0);
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (bus.if_rsp_valid || bus.dm_rsp_valid) begin
            if (bus.if_rsp_valid && bus.dm_rsp_valid) begin
                check("rsp_both_owners", {30'd0, bus.dm_rsp_valid, bus.if_rsp_valid}, 32'd0);
            end else if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", {30'd0, bus.dm_rsp_valid, bus.if_rsp_valid}, 32'd0);
            end else begin
                rsp_t e;
                e = exp_rsp_q.pop_front();
                check("rsp_owner_dm", {31'd0, bus.dm_rsp_valid}, {31'd0, e.is_dm});
                check("rsp_rdata", bus.dm_rsp_valid ? bus.dm_rsp_rdata : bus.if_rsp_rdata, e.data);
            end
        end
    end

    // Grant monitor.
    always @(negedge clk) begin
        logic hs_if, hs_dm;
        hs_if = bus.if_req_valid && bus.if_req_ready;
        hs_dm = bus.dm_req_valid && bus.dm_req_ready;
        if (bus.if_req_ready && bus.dm_req_ready) begin
            check("grant_both", {30'd0, bus.dm_req_ready, bus.if_req_ready}, 32'd0);
        end else if (hs_if || hs_dm) begin
            if (exp_grant_q.size() == 0) begin
                check("grant_unexpected", {30'd0, hs_dm, hs_if}, 32'd0);
            end else begin
                logic g;
                g = exp_grant_q.pop_front();
                check("grant_owner_dm", {31'd0, hs_dm}, {31'd0, g});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic req_if(input logic [31:0] addr);
        bit done;
        done = 1'b0;
        bus.if_req_addr  = addr;
        bus.if_req_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); done = bus.if_req_ready;
            tick();
        end
        bus.if_req_valid = 1'b0;
        check("if_handshake", {31'd0, done}, 32'd1);
    endtask

    task automatic req_dm(input logic [31:0] addr, input logic we, input logic [3:0] be, input logic [31:0] wdata);
        bit done;
        done = 1'b0;
        bus.dm_req_addr  = addr;
        bus.dm_req_we    = we;
        bus.dm_req_be    = be;
        bus.dm_req_wdata = wdata;
        bus.dm_req_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk); done = bus.dm_req_ready;
            tick();
        end
        bus.dm_req_valid = 1'b0;
        check("dm_handshake", {31'd0, done}, 32'd1);
    endtask

    // Both requesters valid; each keeps asking until it has n transactions.
    task automatic drive_both(input int n_if, input int n_dm);
        int  rem_if, rem_dm;
        logic h_if, h_dm;
        rem_if = n_if; rem_dm = n_dm;
        bus.if_req_addr  = 32'h300;
        bus.dm_req_addr  = 32'h404;
        bus.dm_req_we    = 1'b0;
        bus.dm_req_be    = 4'hF;
        bus.dm_req_wdata = 32'h0;
        bus.if_req_valid = 1'b1;
        bus.dm_req_valid = 1'b1;
        for (int c = 0; c < 200 && (rem_if + rem_dm) > 0; c++) begin
            @(negedge clk);
            h_if = bus.if_req_valid && bus.if_req_ready;
            h_dm = bus.dm_req_valid && bus.dm_req_ready;
            tick();
            if (h_if) rem_if--;
            if (h_dm) rem_dm--;
            if (rem_if == 0) bus.if_req_valid = 1'b0;
            if (rem_dm == 0) bus.dm_req_valid = 1'b0;
        end
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        check("both_remaining", 32'(rem_if + rem_dm), 32'd0);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 60 && (exp_rsp_q.size() != 0 || mem_busy); c++) tick();
        repeat (2) tick();
        check(name, 32'(exp_rsp_q.size() + exp_grant_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = '0;
        bus.dm_req_valid = 1'b0;
        bus.dm_req_addr  = '0;
        bus.dm_req_we    = 1'b0;
        bus.dm_req_be    = '0;
        bus.dm_req_wdata = '0;

        // reset state, with IF already asking: no ready may show during reset
        rst_n = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h100;
        repeat (3) tick();
        @(negedge clk);
        check("rst_if_ready",  {31'd0, bus.if_req_ready}, 32'd0);
        check("rst_dm_ready",  {31'd0, bus.dm_req_ready}, 32'd0);
        check("rst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        check("rst_rsp_valid", {30'd0, bus.dm_rsp_valid, bus.if_rsp_valid}, 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'd0);
        check("rst_mem_we_be", {27'd0, bus.mem_we, bus.mem_be}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_rdata",     bus.if_rsp_rdata | bus.dm_rsp_rdata, 32'd0);
        check("rst_err",       {31'd0, bus.err_spurious}, 32'd0);
        tick();
        bus.if_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // IF only read
        exp_grant_q.push_back(1'b0);
        exp_rsp_q.push_back('{is_dm: 1'b0, data: 32'hDEADBEEF});
        req_if(32'h100);
        drain("if_only_drain");

        // DM write with a 3-cycle memory stall; write ack returns zero data
        stall_cycles = 3;
        exp_grant_q.push_back(1'b1);
        exp_rsp_q.push_back('{is_dm: 1'b1, data: 32'h0});
        req_dm(32'h200, 1'b1, 4'b0011, 32'h12345678);
        check("wr_mem_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        check("wr_mem_addr",  bus.mem_addr, 32'h200);
        check("wr_mem_we",    {31'd0, bus.mem_we}, 32'd1);
        check("wr_mem_be",    {28'd0, bus.mem_be}, 32'h3);
        check("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        drain("dm_write_drain");
        stall_cycles = 0;

        // both valid for four transactions, starting from reset
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b1);
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b1);
        exp_rsp_q.push_back('{is_dm: 1'b0, data: 32'hBDEF0300});
        exp_rsp_q.push_back('{is_dm: 1'b1, data: 32'hBAEB0404});
        exp_rsp_q.push_back('{is_dm: 1'b0, data: 32'hBDEF0300});
        exp_rsp_q.push_back('{is_dm: 1'b1, data: 32'hBAEB0404});
`else
        exp_grant_q.push_back(1'b1);
        exp_grant_q.push_back(1'b1);
        exp_grant_q.push_back(1'b0);
        exp_grant_q.push_back(1'b0);
        exp_rsp_q.push_back('{is_dm: 1'b1, data: 32'hBAEB0404});
        exp_rsp_q.push_back('{is_dm: 1'b1, data: 32'hBAEB0404});
        exp_rsp_q.push_back('{is_dm: 1'b0, data: 32'hBDEF0300});
        exp_rsp_q.push_back('{is_dm: 1'b0, data: 32'hBDEF0300});
`endif
        drive_both(2, 2);
        drain("both_drain");

        // spurious response in IDLE
        mem_auto = 1'b0;
        check("pre_spur_err", {31'd0, bus.err_spurious}, 32'd0);
        inj_data = 32'hCAFEF00D;
        inj_rsp  = 1'b1;
        tick();
        inj_rsp  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("spur_err_set", {31'd0, bus.err_spurious}, 32'd1);
        repeat (5) tick();
        @(negedge clk);
        check("spur_err_sticky", {31'd0, bus.err_spurious}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("spur_err_cleared", {31'd0, bus.err_spurious}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset while waiting for memory, then a late response
        exp_grant_q.push_back(1'b1);
        req_dm(32'h500, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        check("mid_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        tick();
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        tick();
        @(negedge clk);
        check("mid_wait_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        inj_data = 32'h11111111;
        inj_rsp  = 1'b1;
        tick();
        inj_rsp  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("late_rsp_err", {31'd0, bus.err_spurious}, 32'd1);
        tick();
        mem_auto = 1'b1;
        exp_grant_q.push_back(1'b0);
        exp_rsp_q.push_back('{is_dm: 1'b0, data: 32'hDEADBEEF});
        req_if(32'h100);
        drain("post_reset_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
